// File: rtl/star_pkg.sv
// rtl/star_pkg.sv - shared sizing constants and FSM state encoding for the STAR data server
package star_pkg;
    localparam int DEPTH   = 256;
    localparam int DW      = 8;
    localparam int AW      = 9;
    localparam int RST_CYC = 2;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_LAUNCH,
        ST_SERVE,
        ST_DONE
    } state_e;
endpackage

// File: rtl/star_byte_mem.sv
// rtl/star_byte_mem.sv - flop-based byte array, one synchronous write port, one combinational read port
module star_byte_mem import star_pkg::*; #(
    parameter int DEPTH = star_pkg::DEPTH,
    parameter int DW    = star_pkg::DW,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    // Contents are deliberately never reset so a reloaded run fully overwrites them.
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/star_data_server.sv
// rtl/star_data_server.sv - loads a byte block, pulses STAR reset, then serves zero-latency reads
module star_data_server import star_pkg::*; #(
    parameter int DEPTH   = star_pkg::DEPTH,
    parameter int DW      = star_pkg::DW,
    parameter int AW      = star_pkg::AW,
    parameter int RST_CYC = star_pkg::RST_CYC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          star_reset,
    input  logic          data_req,
    input  logic [AW-1:0] data_addr,
    output logic [DW-1:0] data,
    input  logic          finish,
    input  logic          rearm,
    output logic          done,
    output logic          oob_err,
    output logic [15:0]   rd_cnt
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] wptr_q, wptr_d;
    logic [15:0]   rd_cnt_q, rd_cnt_d;
    logic [7:0]    rst_cnt_q, rst_cnt_d;
    logic          oob_q, oob_d;
    logic          star_reset_q, star_reset_d;
    logic          done_q, done_d;
    logic          ld_ready_q, ld_ready_d;

    logic          mem_we;
    logic          serving;
    logic          rd_hit;
    logic [DW-1:0] mem_rdata;

    star_byte_mem #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q),
        .wdata (ld_data),
        .raddr (data_addr[IW-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rd_cnt_d = rd_cnt_q;
        rst_cnt_d = rst_cnt_q;
        oob_d    = oob_q;
        mem_we   = (state_q == ST_LOAD) && ld_valid && ld_ready_q;
        serving  = (state_q == ST_SERVE) && data_req;
        rd_hit   = serving && (32'(data_addr) < DEPTH);

        case (state_q)
            ST_LOAD: begin
                if (mem_we) begin
                    wptr_d = wptr_q + IW'(1);
                    if (wptr_q == IW'(DEPTH - 1)) begin
                        state_d   = ST_LAUNCH;
                        wptr_d    = '0;
                        rd_cnt_d  = '0;
                        rst_cnt_d = '0;
                    end
                end
            end
            ST_LAUNCH: begin
                if (rst_cnt_q == 8'(RST_CYC - 1)) begin
                    state_d = ST_SERVE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            ST_SERVE: begin
                if (rd_hit && rd_cnt_q != 16'hFFFF) begin
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end
                if (serving && !rd_hit) begin
                    oob_d = 1'b1;
                end
                if (finish) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rearm) begin
                    state_d = ST_LOAD;
                    oob_d   = 1'b0;
                    wptr_d  = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        // Outputs are registered from the next state so they line up with the state flop.
        star_reset_d = (state_d == ST_LAUNCH);
        done_d       = (state_d == ST_DONE);
        ld_ready_d   = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_LOAD;
            wptr_q       <= '0;
            rd_cnt_q     <= '0;
            rst_cnt_q    <= '0;
            oob_q        <= 1'b0;
            star_reset_q <= 1'b0;
            done_q       <= 1'b0;
            ld_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rd_cnt_q     <= rd_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            oob_q        <= oob_d;
            star_reset_q <= star_reset_d;
            done_q       <= done_d;
            ld_ready_q   <= ld_ready_d;
        end
    end

    assign data       = rd_hit ? mem_rdata : '0;
    assign ld_ready   = ld_ready_q;
    assign star_reset = star_reset_q;
    assign done       = done_q;
    assign oob_err    = oob_q;
    assign rd_cnt     = rd_cnt_q;
endmodule

// File: tb/tb_star_data_server.sv
// tb/tb_star_data_server.sv - directed and randomized checks of star_data_server against a reference model
module tb_star_data_server;
    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        star_reset;
    logic        data_req;
    logic [8:0]  data_addr;
    logic [7:0]  data;
    logic        finish;
    logic        rearm;
    logic        done;
    logic        oob_err;
    logic [15:0] rd_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] ref_mem [256];
    int         exp_cnt;
    bit         exp_oob;

    star_data_server dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .star_reset (star_reset),
        .data_req   (data_req),
        .data_addr  (data_addr),
        .data       (data),
        .finish     (finish),
        .rearm      (rearm),
        .done       (done),
        .oob_err    (oob_err),
        .rd_cnt     (rd_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers bytes until 256 handshakes complete; the model records each accepted byte in order.
    task automatic load_run(input bit rnd, input bit desc);
        int acc = 0;
        int cyc = 0;
        bit early = 0;
        while (acc < 256 && cyc < 5000) begin
            ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = desc ? 8'(255 - acc) : 8'(acc);
            if (star_reset) early = 1;
            if (ld_valid && ld_ready) begin
                ref_mem[acc] = ld_data;
                acc++;
            end
            tick();
            cyc++;
        end
        chk("load_handshakes", 32'(acc), 32'd256);
        chk("launch_early", 32'(early), 32'd0);
        ld_valid = 1'b1;
        ld_data  = 8'hA5;
    endtask

    task automatic wait_launch();
        int n = 0;
        chk("ld_ready_after_load", 32'(ld_ready), 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (!star_reset) break;
            n++;
            tick();
        end
        chk("star_reset_cycles", 32'(n), 32'd2);
        chk("rd_cnt_cleared", 32'(rd_cnt), 32'd0);
        ld_valid = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic rd(input int addr, input string tag);
        logic [7:0] exp;
        data_req  = 1'b1;
        data_addr = 9'(addr);
        #1;
        exp = (addr < 256) ? ref_mem[addr] : 8'h00;
        chk({tag, "_data"}, 32'(data), 32'(exp));
        if (addr < 256) begin
            if (exp_cnt < 65535) exp_cnt++;
        end else begin
            exp_oob = 1;
        end
        tick();
        data_req = 1'b0;
        chk({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(exp_cnt));
        chk({tag, "_oob"}, 32'(oob_err), 32'(exp_oob));
    endtask

    initial begin
        reset = 1'b0; ld_valid = 1'b0; ld_data = '0; data_req = 1'b0;
        data_addr = '0; finish = 1'b0; rearm = 1'b0;
        exp_oob = 0; exp_cnt = 0;
        tick();
        tick();
        chk("rst_star_reset", 32'(star_reset), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_oob", 32'(oob_err), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);

        // Partial load of 100 bytes, then aborted by reset.
        for (int acc = 0; acc < 100;) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = 8'($urandom);
            if (ld_valid && ld_ready) acc++;
            tick();
        end
        ld_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("finish_ignored_in_load", 32'(done), 32'd0);
        chk("ld_ready_after_abort", 32'(ld_ready), 32'd1);

        // Fresh run: 255-i with random offer pattern.
        load_run(1'b1, 1'b1);
        wait_launch();
        rd(0, "addr0_after_abort");
        for (int a = 1; a < 256; a++) rd(a, "mem_readback");
        for (int k = 0; k < 20; k++) rd(int'($urandom_range(0, 511)), "rand_rd");
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        chk("rearm_ignored_in_serve", 32'(done), 32'd0);
        chk("serve_ld_ready", 32'(ld_ready), 32'd0);

        data_req = 1'b1; data_addr = 9'h010; finish = 1'b1;
        #1;
        chk("finish_rd_data", 32'(data), 32'(ref_mem[16]));
        exp_cnt++;
        tick();
        data_req = 1'b0; finish = 1'b0;
        chk("finish_rd_cnt", 32'(rd_cnt), 32'(exp_cnt));
        chk("done_set", 32'(done), 32'd1);
        data_req = 1'b1; data_addr = 9'h003;
        #1;
        chk("done_data_zero", 32'(data), 32'd0);
        tick();
        data_req = 1'b0;
        chk("done_rd_cnt_hold", 32'(rd_cnt), 32'(exp_cnt));
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        exp_oob = 0;
        chk("rearm_done", 32'(done), 32'd0);
        chk("rearm_ld_ready", 32'(ld_ready), 32'd1);
        chk("rearm_oob", 32'(oob_err), 32'd0);

        // Second run: value i with a continuous offer.
        load_run(1'b0, 1'b0);
        wait_launch();
        rd(9'h005, "rd_05");
        rd(9'h0FF, "rd_FF");
        chk("rd_cnt_two", 32'(rd_cnt), 32'd2);
        rd(9'h100, "rd_oob");
        data_req = 1'b0; data_addr = 9'h020;
        #1;
        chk("no_req_data", 32'(data), 32'd0);
        tick();
        chk("no_req_rd_cnt", 32'(rd_cnt), 32'd2);
        data_req = 1'b1; data_addr = 9'h010; finish = 1'b1;
        #1;
        chk("fin2_data", 32'(data), 32'h10);
        tick();
        data_req = 1'b0; finish = 1'b0;
        chk("fin2_rd_cnt", 32'(rd_cnt), 32'd3);
        chk("fin2_done", 32'(done), 32'd1);
        chk("fin2_oob_sticky", 32'(oob_err), 32'd1);
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        chk("rearm2_oob", 32'(oob_err), 32'd0);
        chk("rearm2_ld_ready", 32'(ld_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
